// File: rtl/rnn_mem_arb_if.sv
// ---------------------------------------------------------------------------
// rnn_mem_arb_if -- requester-side bus of the RNN memory arbiter.
//
// Three requesters share this bus. Per-requester fields are packed and
// requester i owns slice i of each field:
//   req    [2:0]   request (0 = weight fetch, 1 = input/bias, 2 = h writeback)
//   lock   [2:0]   hold ownership across cycles while set
//   rwe    [2:0]   1 = write, 0 = read
//   rsel   [8:0]   3-bit memory select,  bits [3i+2:3i]
//   raddr  [50:0]  17-bit address,       bits [17i+16:17i]
//   rwdata [59:0]  20-bit write data,    bits [20i+19:20i]
//   gnt    [2:0]   one-hot-or-zero accept for the current cycle
//   rvalid [2:0]   read data valid for requester i
//   rdata  [19:0]  returned read data, shared by all requesters
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rnn_mem_arb_if;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  rwe;
    logic [8:0]  rsel;
    logic [50:0] raddr;
    logic [59:0] rwdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [19:0] rdata;

    modport master (
        output req, lock, rwe, rsel, raddr, rwdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, rwe, rsel, raddr, rwdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/rnn_mem_arb.sv
// ---------------------------------------------------------------------------
// rnn_mem_arb -- single-port memory arbiter for the RNN datapath.
//
// Arbitrates three requesters (weight fetch, input/bias fetch, hidden-state
// writeback) onto one memory port. At most one command is accepted per
// cycle; the accepted command appears on the memory pins in the following
// cycle and read data comes back two cycles after the accept.
//
// Ports:
//   clk      clock, all state on rising edge
//   reset    synchronous, active-low reset
//   bus      rnn_mem_arb_if.slave requester bus (req/lock/rwe/rsel/raddr/
//            rwdata in, gnt/rvalid/rdata out)
//   mce      memory command enable (registered)
//   msel     memory select (3'b100 when idle)
//   maddr    memory address (held when idle)
//   mdata_w  memory write data (held when idle)
//   mdata_r  memory read data, passed straight through to bus.rdata
//
// Configuration:
//   RNN_ARB_RR_EN  defined   -> round-robin between requesters 0 and 1
//                  undefined -> fixed priority 0 > 1, no pointer register
// Requester 2 (writeback) always wins over 0/1 when nobody owns the port.
// ---------------------------------------------------------------------------
module rnn_mem_arb (
    input  logic          clk,
    input  logic          reset,
    rnn_mem_arb_if.slave  bus,
    output logic          mce,
    output logic [2:0]    msel,
    output logic [16:0]   maddr,
    output logic [19:0]   mdata_w,
    input  logic [19:0]   mdata_r
);

    localparam int DATA_W = 20;
    localparam int ADDR_W = 17;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SEL_IDLE = 3'b100;

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        owner;

    logic              acc;
    logic [1:0]        win;
    logic              pick01;
    logic [2:0]        gnt_c;

    logic              win_we;
    logic [SEL_W-1:0]  win_sel;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic [2:0]        vld_p0;
    logic [2:0]        vld_p1;

    // Choice between requesters 0 and 1 when neither 2 nor an owner applies.
`ifdef RNN_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr names the preferred requester; it only matters when both ask.
    always_comb begin
        pick01 = bus.req[1] && (!bus.req[0] || rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else if (acc && !win[1]) begin
            rr_ptr <= ~win[0];
        end
    end
`else
    always_comb begin
        pick01 = bus.req[1] && !bus.req[0];
    end
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            owner <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && acc && bus.lock[win]) begin
                owner <= win;
            end
        end
    end

    // FSM: next state. Ownership ends in the first cycle the owner drops
    // lock, whether or not it also requests in that cycle.
    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (acc && bus.lock[win]) begin
                state_nxt = OWN;
            end
        end else begin
            if (!bus.lock[owner]) begin
                state_nxt = IDLE;
            end
        end
    end

    // FSM: outputs (accept decision). An owner with req=0 produces an idle
    // cycle; other requesters, including writeback, are not served then.
    always_comb begin
        acc = 1'b0;
        win = 2'd0;
        if (reset) begin
            if (state == OWN) begin
                if (bus.req[owner]) begin
                    acc = 1'b1;
                    win = owner;
                end
            end else if (bus.req[2]) begin
                acc = 1'b1;
                win = 2'd2;
            end else if (bus.req[0] || bus.req[1]) begin
                acc = 1'b1;
                win = {1'b0, pick01};
            end
        end
        gnt_c = acc ? (3'b001 << win) : 3'b000;
    end

    assign bus.gnt = gnt_c;

    // Fields of the winning requester; other requesters' fields are ignored.
    always_comb begin
        win_we   = bus.rwe[0];
        win_sel  = bus.rsel[2:0];
        win_addr = bus.raddr[16:0];
        win_data = bus.rwdata[19:0];
        case (win)
            2'd1: begin
                win_we   = bus.rwe[1];
                win_sel  = bus.rsel[5:3];
                win_addr = bus.raddr[33:17];
                win_data = bus.rwdata[39:20];
            end
            2'd2: begin
                win_we   = bus.rwe[2];
                win_sel  = bus.rsel[8:6];
                win_addr = bus.raddr[50:34];
                win_data = bus.rwdata[59:40];
            end
            default: ;
        endcase
    end

    // Stage p0: memory command registered at the end of the accept cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mce     <= 1'b0;
            msel    <= SEL_IDLE;
            maddr   <= '0;
            mdata_w <= '0;
        end else if (acc) begin
            mce     <= 1'b1;
            msel    <= win_sel;
            maddr   <= win_addr;
            mdata_w <= win_data;
        end else begin
            mce     <= 1'b0;
            msel    <= SEL_IDLE;
        end
    end

    // Stage p0 -> p1: read tag follows the command so rvalid lines up with
    // the memory's read latency. Reset flushes in-flight reads.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0 <= 3'b000;
            vld_p1 <= 3'b000;
        end else begin
            vld_p0 <= (acc && !win_we) ? gnt_c : 3'b000;
            vld_p1 <= vld_p0;
        end
    end

    assign bus.rvalid = vld_p1;
    assign bus.rdata  = mdata_r;

endmodule

// File: tb/tb_rnn_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_rnn_mem_arb -- self-checking bench for rnn_mem_arb.
// A directed table, hand-written multi-cycle sequences and a randomized
// phase, all checked every cycle against a behavioural reference model.
// Build with +define+RNN_ARB_RR_EN to exercise the round-robin variant.
// ---------------------------------------------------------------------------
module tb_rnn_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] mdata_r;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;

    always #5 clk = ~clk;

    rnn_mem_arb_if bus();

    rnn_mem_arb dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .mce     (mce),
        .msel    (msel),
        .maddr   (maddr),
        .mdata_w (mdata_w),
        .mdata_r (mdata_r)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    typedef struct {
        int due;
        int idx;
    } rd_t;

    rd_t         rdq[$];
    int          m_owner;
    logic        m_mce;
    logic [2:0]  m_msel;
    logic [16:0] m_maddr;
    logic [19:0] m_mdata_w;
`ifdef RNN_ARB_RR_EN
    int          m_rr;
`endif

    // last observed DUT outputs
    logic [2:0]  obs_gnt;
    logic        obs_mce;
    logic [2:0]  obs_msel;
    logic [16:0] obs_maddr;
    logic [19:0] obs_mdata_w;
    logic [2:0]  obs_rv;
    logic [19:0] obs_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] model_gnt();
        if (!reset) return 3'b000;
        if (m_owner >= 0) return bus.req[m_owner] ? 3'(1 << m_owner) : 3'b000;
        if (bus.req[2]) return 3'b100;
`ifdef RNN_ARB_RR_EN
        if (bus.req[0] && bus.req[1]) return (m_rr == 0) ? 3'b001 : 3'b010;
`endif
        if (bus.req[0]) return 3'b001;
        if (bus.req[1]) return 3'b010;
        return 3'b000;
    endfunction

    function automatic int idx_of(input logic [2:0] g);
        if (g[0]) return 0;
        if (g[1]) return 1;
        return 2;
    endfunction

    task automatic rand_bus();
        bus.rsel   = 9'($urandom);
        bus.raddr  = 51'({$urandom, $urandom});
        bus.rwdata = 60'({$urandom, $urandom});
        mdata_r    = 20'($urandom);
    endtask

    // One clock cycle: sample and check at the falling edge, then advance
    // the model to what the memory side should look like next cycle.
    task automatic cycle();
        logic [2:0] eg;
        logic [2:0] erv;
        int         w;
        @(negedge clk);
        eg  = model_gnt();
        erv = 3'b000;
        foreach (rdq[i]) if (rdq[i].due == cyc) erv |= 3'(1 << rdq[i].idx);
        obs_gnt     = bus.gnt;
        obs_mce     = mce;
        obs_msel    = msel;
        obs_maddr   = maddr;
        obs_mdata_w = mdata_w;
        obs_rv      = bus.rvalid;
        obs_rdata   = bus.rdata;
        chk("gnt", obs_gnt, eg);
        chk("mce", obs_mce, m_mce);
        chk("msel", obs_msel, m_msel);
        chk("maddr", obs_maddr, m_maddr);
        chk("mdata_w", obs_mdata_w, m_mdata_w);
        chk("rvalid", obs_rv, erv);
        if (erv != 3'b000) chk("rdata", obs_rdata, mdata_r);

        w = idx_of(eg);
        if (!reset) begin
            m_owner   = -1;
            m_mce     = 1'b0;
            m_msel    = 3'b100;
            m_maddr   = '0;
            m_mdata_w = '0;
            rdq.delete();
`ifdef RNN_ARB_RR_EN
            m_rr      = 0;
`endif
        end else begin
            if (eg != 3'b000) begin
                m_mce     = 1'b1;
                m_msel    = bus.rsel[3*w +: 3];
                m_maddr   = bus.raddr[17*w +: 17];
                m_mdata_w = bus.rwdata[20*w +: 20];
                if (!bus.rwe[w]) rdq.push_back('{cyc + 2, w});
`ifdef RNN_ARB_RR_EN
                if (w < 2) m_rr = 1 - w;
`endif
            end else begin
                m_mce  = 1'b0;
                m_msel = 3'b100;
            end
            if (m_owner >= 0) begin
                if (!bus.lock[m_owner]) m_owner = -1;
            end else if (eg != 3'b000 && bus.lock[w]) begin
                m_owner = w;
            end
        end
        while (rdq.size() > 0 && rdq[0].due <= cyc) void'(rdq.pop_front());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic       rst_n;
        logic [2:0] req;
        logic [2:0] lock;
        logic [2:0] gnt;
        logic       mce;
    } vec_t;

`ifdef RNN_ARB_RR_EN
    localparam logic [2:0] G_ALT = 3'b010;
`else
    localparam logic [2:0] G_ALT = 3'b001;
`endif

    vec_t tbl[18];
    int   n0;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0};
        tbl[2]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0};
        tbl[3]  = '{1'b1, 3'b111, 3'b000, 3'b100, 1'b0};
        tbl[4]  = '{1'b1, 3'b011, 3'b000, 3'b001, 1'b1};
        tbl[5]  = '{1'b1, 3'b011, 3'b000, G_ALT,  1'b1};
        tbl[6]  = '{1'b1, 3'b011, 3'b000, 3'b001, 1'b1};
        tbl[7]  = '{1'b1, 3'b011, 3'b000, G_ALT,  1'b1};
        tbl[8]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b1};
        tbl[9]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[10] = '{1'b1, 3'b010, 3'b010, 3'b010, 1'b0};
        tbl[11] = '{1'b1, 3'b111, 3'b010, 3'b010, 1'b1};
        tbl[12] = '{1'b1, 3'b101, 3'b010, 3'b000, 1'b1};
        tbl[13] = '{1'b1, 3'b110, 3'b000, 3'b010, 1'b0};
        tbl[14] = '{1'b1, 3'b111, 3'b000, 3'b100, 1'b1};
        tbl[15] = '{1'b1, 3'b001, 3'b001, 3'b001, 1'b1};
        tbl[16] = '{1'b1, 3'b100, 3'b000, 3'b000, 1'b1};
        tbl[17] = '{1'b1, 3'b100, 3'b000, 3'b100, 1'b0};

        m_owner   = -1;
        m_mce     = 1'b0;
        m_msel    = 3'b100;
        m_maddr   = '0;
        m_mdata_w = '0;
`ifdef RNN_ARB_RR_EN
        m_rr      = 0;
`endif
        reset    = 1'b0;
        bus.req  = 3'b000;
        bus.lock = 3'b000;
        bus.rwe  = 3'b000;
        rand_bus();
        repeat (2) @(posedge clk);
        #1;

        // directed table (all writes, so no read data in flight)
        for (int i = 0; i < 18; i++) begin
            rand_bus();
            reset    = tbl[i].rst_n;
            bus.req  = tbl[i].req;
            bus.lock = tbl[i].lock;
            bus.rwe  = 3'b111;
            cycle();
            chk($sformatf("tbl%0d_gnt", i), obs_gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_mce", i), obs_mce, tbl[i].mce);
        end

        // single read by requester 1
        rand_bus();
        bus.req = 3'b010; bus.lock = 3'b000; bus.rwe = 3'b000;
        bus.rsel[5:3] = 3'b001; bus.raddr[33:17] = 17'd5;
        cycle();
        chk("rd1_gnt", obs_gnt, 3'b010);
        rand_bus();
        bus.req = 3'b000;
        cycle();
        chk("rd1_mce", obs_mce, 1'b1);
        chk("rd1_maddr", obs_maddr, 17'd5);
        chk("rd1_msel", obs_msel, 3'b001);
        chk("rd1_rv_early", obs_rv, 3'b000);
        rand_bus();
        mdata_r = 20'h0ABCD;
        cycle();
        chk("rd1_rvalid", obs_rv, 3'b010);
        chk("rd1_rdata", obs_rdata, 20'h0ABCD);
        rand_bus();
        cycle();
        chk("rd1_rv_once", obs_rv, 3'b000);

        // write by requester 2
        rand_bus();
        bus.req = 3'b100; bus.rwe = 3'b100;
        bus.rsel[8:6] = 3'b101; bus.raddr[50:34] = 17'h00841; bus.rwdata[59:40] = 20'h10000;
        cycle();
        chk("wr2_gnt", obs_gnt, 3'b100);
        rand_bus();
        bus.req = 3'b000;
        cycle();
        chk("wr2_mce", obs_mce, 1'b1);
        chk("wr2_msel", obs_msel, 3'b101);
        chk("wr2_maddr", obs_maddr, 17'h00841);
        chk("wr2_mdata_w", obs_mdata_w, 20'h10000);
        rand_bus();
        cycle();
        chk("wr2_no_rv", obs_rv, 3'b000);

        // locked owner holds the port over a pending writeback for 64 cycles
        n0 = 0;
        rand_bus();
        bus.req = 3'b001; bus.lock = 3'b001; bus.rwe = 3'($urandom);
        cycle();
        if (obs_gnt == 3'b001) n0++;
        for (int i = 0; i < 63; i++) begin
            rand_bus();
            bus.req = 3'b101; bus.rwe = 3'($urandom);
            cycle();
            if (obs_gnt == 3'b001) n0++;
        end
        chk("lock_grants", n0, 64);
        rand_bus();
        bus.req = 3'b100; bus.lock = 3'b000;
        cycle();
        chk("unlock_gnt", obs_gnt, 3'b000);
        rand_bus();
        cycle();
        chk("after_unlock_gnt", obs_gnt, 3'b100);

        // reset right after a read accept drops the read
        rand_bus();
        bus.req = 3'b001; bus.rwe = 3'b000;
        cycle();
        chk("rst_rd_gnt", obs_gnt, 3'b001);
        rand_bus();
        reset = 1'b0; bus.req = 3'b000;
        cycle();
        rand_bus();
        reset = 1'b1;
        cycle();
        chk("rst_rd_rv_c2", obs_rv, 3'b000);
        rand_bus();
        cycle();
        chk("rst_rd_rv_c3", obs_rv, 3'b000);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rand_bus();
            reset    = ($urandom_range(0, 49) != 0);
            bus.req  = 3'($urandom);
            bus.lock = 3'($urandom) & 3'($urandom);
            bus.rwe  = 3'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
